// File: rtl/meas_pkg.sv
// Shared types and helpers for the measurement frame reader: the one-hot
// controller state encoding, the frame header byte and the frame length rule.
package meas_pkg;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b000_0001,
    ST_START     = 7'b000_0010,
    ST_WAIT_BUSY = 7'b000_0100,
    ST_WAIT_DONE = 7'b000_1000,
    ST_LATCH     = 7'b001_0000,
    ST_SEND      = 7'b010_0000,
    ST_DONE      = 7'b100_0000
  } state_e;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Header byte + one byte per result byte + trailing checksum byte.
  function automatic int frame_len(input int nCh, input int valW);
    return 2 + nCh * valW / 8;
  endfunction

endpackage

// File: rtl/meas_frame_ser.sv
// Frame serializer: holds the result snapshot and streams header, payload
// (each channel LSB first, channel 0 first) and an 8-bit running checksum
// over a valid/ready byte port. The snapshot is shifted down one byte per
// payload byte presented, so no wide multiplexer is needed.
module meas_frame_ser
  import meas_pkg::*;
#(
  parameter int N_CH  = 10,
  parameter int VAL_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [N_CH*VAL_W-1:0] snap_i,
  input  logic                  tx_ready_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  output logic                  last_accept_o
);

  localparam int FRAME_L = frame_len(N_CH, VAL_W);
  localparam int IDX_W   = $clog2(FRAME_L);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_L - 1);

  logic [N_CH*VAL_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]      byteIdx_q, byteIdx_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            txData_q, txData_d;
  logic                  txValid_q, txValid_d;
  logic                  accept;
  logic                  isPayload;

  assign accept        = txValid_q && tx_ready_i;
  assign isPayload     = (byteIdx_q != '0) && (byteIdx_q != IDX_LAST);
  assign last_accept_o = accept && (byteIdx_q == IDX_LAST);
  assign tx_data_o     = txData_q;
  assign tx_valid_o    = txValid_q;

  // Next byte selection and checksum accumulation on each accepted byte.
  always_comb begin
    snap_d    = snap_q;
    byteIdx_d = byteIdx_q;
    csum_d    = csum_q;
    txData_d  = txData_q;
    txValid_d = txValid_q;
    if (load_i) begin
      snap_d    = snap_i;
      byteIdx_d = '0;
      csum_d    = 8'h00;
      txData_d  = FRAME_HDR;
      txValid_d = 1'b1;
    end else if (accept) begin
      if (byteIdx_q == IDX_LAST) begin
        txValid_d = 1'b0;
        txData_d  = 8'h00;
      end else begin
        byteIdx_d = byteIdx_q + 1'b1;
        if (isPayload) begin
          csum_d = csum_q + txData_q;
        end
        if (byteIdx_d == IDX_LAST) begin
          txData_d = csum_d;
        end else begin
          txData_d = snap_q[7:0];
          snap_d   = snap_q >> 8;
        end
      end
    end
  end

  // Output stage and snapshot registers; reset abandons any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q    <= '0;
      byteIdx_q <= '0;
      csum_q    <= 8'h00;
      txData_q  <= 8'h00;
      txValid_q <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      byteIdx_q <= byteIdx_d;
      csum_q    <= csum_d;
      txData_q  <= txData_d;
      txValid_q <= txValid_d;
    end
  end

endmodule

// File: rtl/meas_frame_reader.sv
// Initiator side of the meter start/busy handshake. A trigger starts one
// measurement; once the meter has gone busy and idle again the results are
// latched and handed to the serializer as one framed byte sequence. Each
// wait state is bounded by a cycle counter that aborts with a sticky flag.
module meas_frame_reader
  import meas_pkg::*;
#(
  parameter int N_CH        = 10,
  parameter int VAL_W       = 32,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trigger_i,
  output logic                  meas_start_o,
  input  logic                  meas_busy_i,
  input  logic [N_CH*VAL_W-1:0] meas_val_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  frame_done_o,
  output logic                  timeout_err_o,
  output logic                  idle_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic             measStart_q;
  logic             frameDone_q;
  logic             loadSnap;
  logic             frameSent;

  // Controller next state, wait counter and abort flag; the awaited meter
  // condition is tested before the timeout so it wins a same-cycle tie.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    timeoutErr_d = timeoutErr_q;
    loadSnap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger_i) begin
          state_d      = ST_START;
          timeoutErr_d = 1'b0;
        end
      end
      ST_START: begin
        state_d   = ST_WAIT_BUSY;
        waitCnt_d = '0;
      end
      ST_WAIT_BUSY: begin
        if (meas_busy_i) begin
          state_d   = ST_WAIT_DONE;
          waitCnt_d = '0;
        end else if (waitCnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          timeoutErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!meas_busy_i) begin
          state_d = ST_LATCH;
        end else if (waitCnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          timeoutErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        loadSnap = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (frameSent) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered control outputs; the start pulse is the
  // registered image of the START state, giving a two-edge trigger latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
      measStart_q  <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
      measStart_q  <= (state_q == ST_START);
      frameDone_q  <= (state_d == ST_DONE);
    end
  end

  meas_frame_ser #(
    .N_CH (N_CH),
    .VAL_W(VAL_W)
  ) u_ser (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (loadSnap),
    .snap_i       (meas_val_i),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .last_accept_o(frameSent)
  );

  assign meas_start_o  = measStart_q;
  assign frame_done_o  = frameDone_q;
  assign timeout_err_o = timeoutErr_q;
  assign idle_o        = (state_q == ST_IDLE);

endmodule
